// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, registered instruction output, branch flush and HALT state.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [7:0]  branch_target,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {RUN, HALT} state_e;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HaltDetectEn = 1'b1;
`else
  localparam bit HaltDetectEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic        is_halt_word;

  assign is_halt_word = HaltDetectEn && (mem_rdata == HALT_WORD);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    count_d    = count_q;
    unique case (state_q)
      RUN: begin
        // Branch outranks stall: redirect and flush even while decode is stalled.
        if (branch_en) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (!stall) begin
          if (is_halt_word) begin
            state_d = HALT;
            valid_d = 1'b0;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 8'd1;
            count_d    = (count_q == '1) ? count_q : count_q + 16'd1;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (branch_en) begin
          state_d = RUN;
          pc_d    = branch_target;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign mem_addr    = pc_q;
  assign mem_we      = 1'b0;
  assign mem_din     = '0;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/branch/reset traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_en;
  logic [7:0]  branch_target;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_din, mem_rdata;
  logic [15:0] instr, fetch_count;
  logic [7:0]  instr_pc;
  logic        instr_valid, halted;

  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  fetch_stage #(.RESET_PC(8'h00), .HALT_WORD(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_rdata(mem_rdata), .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: one architectural step per rising edge.
  int   m_pc, m_instr, m_ipc, m_count;
  bit   m_valid, m_halt, m_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_count = 0; m_halt = 0; m_ok = 1'b1;
    end else if (branch_en) begin
      m_pc = branch_target; m_valid = 0; m_halt = 0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (!stall) begin
      if (HALT_EN && mem[m_pc] == 16'hFFFF) begin
        m_halt = 1; m_valid = 0;
      end else begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1;
        m_pc = (m_pc + 1) % 256;
        m_count = (m_count + 1 > 65535) ? 65535 : m_count + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("mem_addr",    32'(mem_addr),    32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr",       32'(instr),       32'(m_instr));
      chk("instr_pc",    32'(instr_pc),    32'(m_ipc));
      chk("halted",      32'(halted),      32'(m_halt));
      chk("fetch_count", 32'(fetch_count), 32'(m_count));
      chk("mem_we",      32'(mem_we),      32'h0);
      chk("mem_din",     32'(mem_din),     32'h0);
    end
  end

  task automatic step(input logic r, input logic s, input logic b, input logic [7:0] t);
    rst_n = r; stall = s; branch_en = b; branch_target = t;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom) & 16'h7FFF;
    mem[0] = 16'h007D; mem[1] = 16'h1024; mem[2] = 16'h5005; mem[3] = 16'hFFFF;
    rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = 8'h00;

    // Reset, with stall and branch asserted to show reset wins.
    step(1'b0, 1'b1, 1'b1, 8'h40);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_count", 32'(fetch_count), 32'h0);
    chk("rst_addr",  32'(mem_addr),    32'h00);
    chk("rst_instr", 32'(instr),       32'h0000);
    chk("rst_halt",  32'(halted),      32'h0);

    // Sequential fetch.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("seq0_instr", 32'(instr), 32'h007D); chk("seq0_pc", 32'(instr_pc), 32'h00);
    chk("seq0_valid", 32'(instr_valid), 32'h1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("seq1_instr", 32'(instr), 32'h1024); chk("seq1_pc", 32'(instr_pc), 32'h01);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("seq2_instr", 32'(instr), 32'h5005); chk("seq2_pc", 32'(instr_pc), 32'h02);
    chk("seq_count", 32'(fetch_count), 32'd3);

    // HALT word at address 3.
    step(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef FETCH_HALT_DETECT_EN
    chk("halt_flag",  32'(halted),      32'h1);
    chk("halt_valid", 32'(instr_valid), 32'h0);
    chk("halt_addr",  32'(mem_addr),    32'h03);
    chk("halt_count", 32'(fetch_count), 32'd3);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("halt_hold_addr", 32'(mem_addr), 32'h03);
`else
    chk("nohalt_instr", 32'(instr),       32'hFFFF);
    chk("nohalt_valid", 32'(instr_valid), 32'h1);
    chk("nohalt_addr",  32'(mem_addr),    32'h04);
    chk("nohalt_flag",  32'(halted),      32'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
`endif

    // Reset in the middle of a halt (or run).
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("mid_rst_halt",  32'(halted),      32'h0);
    chk("mid_rst_valid", 32'(instr_valid), 32'h0);
    chk("mid_rst_count", 32'(fetch_count), 32'h0);
    chk("mid_rst_addr",  32'(mem_addr),    32'h00);

    // Stall holds everything for three cycles.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("st_first", 32'(instr), 32'h007D);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      chk("st_instr", 32'(instr),       32'h007D);
      chk("st_addr",  32'(mem_addr),    32'h01);
      chk("st_count", 32'(fetch_count), 32'd1);
      chk("st_valid", 32'(instr_valid), 32'h1);
    end

    // Branch beats simultaneous stall.
    step(1'b1, 1'b1, 1'b1, 8'h02);
    chk("br_valid", 32'(instr_valid), 32'h0);
    chk("br_addr",  32'(mem_addr),    32'h02);
    chk("br_instr_held", 32'(instr),  32'h007D);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("br_instr", 32'(instr), 32'h5005);
    chk("br_pc",    32'(instr_pc), 32'h02);

    // PC wrap.
    step(1'b1, 1'b0, 1'b1, 8'hFF);
    chk("wr_addr", 32'(mem_addr), 32'hFF);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("wr_pc_ff", 32'(instr_pc), 32'hFF);
    chk("wr_addr0", 32'(mem_addr), 32'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("wr_pc_00", 32'(instr_pc), 32'h00);
    chk("wr_instr", 32'(instr),    32'h007D);

    // Randomized traffic, some HALT words sprinkled in memory.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom);
    for (int c = 0; c < 3000; c++)
      step(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 9) == 0), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
